// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the parametrised LFSR word generator.
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIBONACCI = 1'b0,
    LFSR_GALOIS    = 1'b1
  } lfsr_mode_e;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } lfsr_state_e;

  // Galois XOR mask: the tap mask rotated left by one within the register width.
  function automatic logic [63:0] lfsr_galois_mask(input logic [63:0] taps, input int width);
    logic [63:0] g;
    g    = '0;
    g[0] = taps[width-1];
    for (int i = 1; i < 64; i++) begin
      if (i < width) g[i] = taps[i-1];
    end
    return g;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational single-bit LFSR shift, Fibonacci or Galois form.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter lfsr_mode_e       MODE  = LFSR_FIBONACCI
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (MODE == LFSR_GALOIS) begin : g_galois
    localparam logic [WIDTH-1:0] GMASK = WIDTH'(lfsr_galois_mask(64'(TAPS), WIDTH));
    assign q = {d[WIDTH-2:0], 1'b0} ^ (d[WIDTH-1] ? GMASK : '0);
  end else begin : g_fibonacci
    assign q = {d[WIDTH-2:0], ^(d & TAPS)};
  end

endmodule

// File: rtl/lfsr_stream.sv
// LFSR word source with valid/ready output stream and a seed load port.
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
  parameter logic [WIDTH-1:0] INITIAL_FILL = 16'h0001,
  parameter lfsr_mode_e       MODE         = LFSR_FIBONACCI,
  parameter int               STEPS        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_seed_valid,
  input  logic [WIDTH-1:0] i_seed,
  output logic             o_seed_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_out,
  output logic             o_lockup
);

  if (WIDTH < 3 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "lfsr_stream: WIDTH must be in 3..64");
  end
  if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
    $fatal(1, "lfsr_stream: TAPS must include the x^WIDTH term");
  end
  if (INITIAL_FILL == '0) begin : g_bad_fill
    $fatal(1, "lfsr_stream: INITIAL_FILL must be non-zero");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $fatal(1, "lfsr_stream: STEPS must be in 1..WIDTH");
  end

  lfsr_state_e                  state_q, state_d;
  logic        [WIDTH-1:0]      r_q, r_d;
  logic                         lockup_q, lockup_d;
  logic        [STEPS:0][WIDTH-1:0] chain;
  logic                         seed_hs, out_hs, seed_zero;

  // Word advance: STEPS single shifts chained within one cycle.
  assign chain[0] = r_q;
  for (genvar i = 0; i < STEPS; i++) begin : g_chain
    lfsr_step #(
      .WIDTH(WIDTH),
      .TAPS (TAPS),
      .MODE (MODE)
    ) u_step (
      .d(chain[i]),
      .q(chain[i+1])
    );
  end

  assign o_valid      = (state_q == RUN);
  assign o_seed_ready = (state_q == RUN);
  assign o_out        = r_q;
  assign o_lockup     = lockup_q;

  assign seed_hs   = i_seed_valid & o_seed_ready;
  assign out_hs    = o_valid & i_ready;
  assign seed_zero = (i_seed == '0);

  // A seed load takes priority over a simultaneous output advance.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    lockup_d = 1'b0;
    case (state_q)
      FILL: state_d = RUN;
      RUN: begin
        if (seed_hs) begin
          state_d  = FILL;
          r_d      = seed_zero ? INITIAL_FILL : i_seed;
          lockup_d = seed_zero;
        end else if (out_hs) begin
          r_d = chain[STEPS];
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      r_q      <= INITIAL_FILL;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      lockup_q <= lockup_d;
    end
  end

endmodule
